a2d_arbiter: RTL and testbench

- Shares the single A2D converter interface between two independent requesters.
- Requester 0 is the motion controller's IR sampling sequencer; requester 1 is the battery/housekeeping monitor.
- Each requester issues a one-cycle start with a channel number. The arbiter queues it, grants the converter round-robin, drives the converter's channel and start, and returns the 12-bit result with a one-cycle complete strobe.
- A watchdog aborts conversions that never complete.

---
 rtl/a2d_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_a2d_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_arbiter.sv
// a2d_arbiter: shares one A2D converter between two requesters, round-robin, with a conversion watchdog.
// Latency: reqN_strt -> a2d_strt two cycles later; a2d_cmplt -> reqN_cmplt/res one cycle later.
// Backpressure: one outstanding request per requester; a repeat start while pending is dropped, except in its own DONE cycle.
module a2d_arbiter #(
    parameter int unsigned TMO_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_strt,
    input  logic [2:0]  req0_chnnl,
    output logic        req0_cmplt,
    input  logic        req1_strt,
    input  logic [2:0]  req1_chnnl,
    output logic        req1_cmplt,
    output logic [11:0] res,
    output logic        a2d_strt,
    output logic [2:0]  a2d_chnnl,
    input  logic        a2d_cmplt,
    input  logic [11:0] a2d_res,
    output logic        busy,
    output logic        tmo_err
);

    // Watchdog limit in the counter's own width (legal range 1..1023).
    localparam logic [9:0] LP_TMO = 10'(TMO_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CONV  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_gnt;
    logic        w_gnt_nxt;
    logic        r_last;
    logic [1:0]  r_pend;
    logic [2:0]  r_chnnl0;
    logic [2:0]  r_chnnl1;
    logic [9:0]  r_wdog;
    logic [9:0]  w_wdog_inc;
    logic        w_take_res;
    logic        w_abort;
    logic        w_done0;
    logic        w_done1;

    logic        r_req0_cmplt;
    logic        r_req1_cmplt;
    logic [11:0] r_res;
    logic        r_a2d_strt;
    logic [2:0]  r_a2d_chnnl;
    logic        r_busy;
    logic        r_tmo_err;

    assign w_wdog_inc = r_wdog + 10'd1;

    // DONE cycle for each requester: its pend clears here unless it re-strobes.
    assign w_done0 = (r_state == DONE) && !r_gnt;
    assign w_done1 = (r_state == DONE) &&  r_gnt;

    // Next-state, grant selection and conversion termination decode.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_take_res  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend != 2'b00) begin
                    w_state_nxt = GRANT;
                    // On a tie the requester that was not served last wins.
                    if (r_pend == 2'b11) begin
                        w_gnt_nxt = ~r_last;
                    end else begin
                        w_gnt_nxt = r_pend[1];
                    end
                end
            end
            GRANT: begin
                w_state_nxt = CONV;
            end
            CONV: begin
                // A completion in the same cycle as the timeout takes priority.
                if (a2d_cmplt) begin
                    w_take_res  = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_wdog_inc == LP_TMO) begin
                    w_abort     = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register and latched grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    // Watchdog: cleared in GRANT, counts every CONV cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= 10'd0;
        end else if (r_state == GRANT) begin
            r_wdog <= 10'd0;
        end else if (r_state == CONV) begin
            r_wdog <= w_wdog_inc;
        end
    end

    // Request capture; a start in the requester's own DONE cycle beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend   <= 2'b00;
            r_chnnl0 <= 3'd0;
            r_chnnl1 <= 3'd0;
        end else begin
            if (req0_strt && (!r_pend[0] || w_done0)) begin
                r_pend[0] <= 1'b1;
                r_chnnl0  <= req0_chnnl;
            end else if (w_done0) begin
                r_pend[0] <= 1'b0;
            end
            if (req1_strt && (!r_pend[1] || w_done1)) begin
                r_pend[1] <= 1'b1;
                r_chnnl1  <= req1_chnnl;
            end else if (w_done1) begin
                r_pend[1] <= 1'b0;
            end
        end
    end

    // Last-granted pointer; starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (r_state == DONE) begin
            r_last <= r_gnt;
        end
    end

    // Converter-side outputs: start pulse in GRANT, channel latched at grant and held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a2d_strt  <= 1'b0;
            r_a2d_chnnl <= 3'd0;
            r_busy      <= 1'b0;
        end else begin
            r_a2d_strt <= (w_state_nxt == GRANT);
            r_busy     <= (w_state_nxt != IDLE);
            if ((r_state == IDLE) && (w_state_nxt == GRANT)) begin
                r_a2d_chnnl <= w_gnt_nxt ? r_chnnl1 : r_chnnl0;
            end
        end
    end

    // Requester-side outputs: strobes coincide with DONE, result held between conversions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req0_cmplt <= 1'b0;
            r_req1_cmplt <= 1'b0;
            r_tmo_err    <= 1'b0;
            r_res        <= 12'h000;
        end else begin
            r_req0_cmplt <= (w_state_nxt == DONE) && !r_gnt;
            r_req1_cmplt <= (w_state_nxt == DONE) &&  r_gnt;
            r_tmo_err    <= w_abort;
            if (w_take_res) begin
                r_res <= a2d_res;
            end else if (w_abort) begin
                r_res <= 12'h000;
            end
        end
    end

    assign req0_cmplt = r_req0_cmplt;
    assign req1_cmplt = r_req1_cmplt;
    assign res        = r_res;
    assign a2d_strt   = r_a2d_strt;
    assign a2d_chnnl  = r_a2d_chnnl;
    assign busy       = r_busy;
    assign tmo_err    = r_tmo_err;

    // Structural invariants of the handshake.
    a_one_cmplt: assert property (@(posedge clk) disable iff (!rst_n)
        !(req0_cmplt && req1_cmplt));
    a_strt_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        a2d_strt |=> !a2d_strt);
    a_tmo_with_cmplt: assert property (@(posedge clk) disable iff (!rst_n)
        tmo_err |-> (req0_cmplt || req1_cmplt));

endmodule

// File: tb/tb_a2d_arbiter.sv
// tb_a2d_arbiter: randomized bench with a converter responder and a scoreboard monitor.
// Expected grant order, channel, result, abort flag and completion cycle come from a request-level model.
// The monitor compares every cycle; stimulus only drives pins and waits for the model to drain.
module tb_a2d_arbiter;

    localparam int TMO = 16;

    logic        clk;
    logic        rst_n;
    logic        req0_strt;
    logic [2:0]  req0_chnnl;
    logic        req0_cmplt;
    logic        req1_strt;
    logic [2:0]  req1_chnnl;
    logic        req1_cmplt;
    logic [11:0] res;
    logic        a2d_strt;
    logic [2:0]  a2d_chnnl;
    logic        a2d_cmplt;
    logic [11:0] a2d_res;
    logic        busy;
    logic        tmo_err;

    a2d_arbiter #(.TMO_CYC(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_strt  (req0_strt),
        .req0_chnnl (req0_chnnl),
        .req0_cmplt (req0_cmplt),
        .req1_strt  (req1_strt),
        .req1_chnnl (req1_chnnl),
        .req1_cmplt (req1_cmplt),
        .res        (res),
        .a2d_strt   (a2d_strt),
        .a2d_chnnl  (a2d_chnnl),
        .a2d_cmplt  (a2d_cmplt),
        .a2d_res    (a2d_res),
        .busy       (busy),
        .tmo_err    (tmo_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          req;
        logic [11:0] res;
        logic        tmo;
        int          done_cyc;
    } exp_t;

    exp_t        sb[$];

    // Request-level model (owned by the monitor).
    logic        m_pend [2];
    logic [2:0]  m_chan [2];
    int          m_issue [2];
    int          m_last;
    int          m_svc;
    int          m_idle_free;
    logic [2:0]  m_last_ch;
    logic [11:0] m_last_res;
    int          cyc;
    int          n_vec;
    int          n_err;

    // Converter behaviour knobs (stimulus) and the response it chose (converter).
    int          cv_mode;
    int          cv_fix_k;
    logic [11:0] cv_fix_res;
    int          cv_k;
    logic        cv_tmo;
    logic [11:0] cv_res;
    int          cv_cnt;

    // Stimulus-owned controls.
    logic        drain_chk;
    logic        drain_ok;
    int          restrobe_cnt;
    bit          rand_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i]  = 1'b0;
            m_chan[i]  = 3'd0;
            m_issue[i] = 0;
        end
        m_last      = 1;
        m_svc       = -1;
        m_idle_free = -10;
        m_last_ch   = 3'd0;
        m_last_res  = 12'h000;
        sb.delete();
    endtask

    // Monitor: predicts grants and completions from the request history and checks every cycle.
    initial begin : monitor
        bit   e0;
        bit   e1;
        bit   exp_strt;
        int   g;
        exp_t e;
        cyc   = 0;
        n_vec = 0;
        n_err = 0;
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("reset_outputs", 32'({req0_cmplt, req1_cmplt, res, a2d_strt, a2d_chnnl, busy, tmo_err}), 32'd0);
                model_reset();
            end else begin
                if (drain_chk) chk("drain_done", 32'(drain_ok), 32'd1);
                // A request issued in cycle t is visible to arbitration in t+1, so grant no earlier than t+2.
                e0 = m_pend[0] && (m_issue[0] <= cyc - 2);
                e1 = m_pend[1] && (m_issue[1] <= cyc - 2);
                exp_strt = (m_svc < 0) && (cyc >= m_idle_free + 1) && (e0 || e1);
                chk("a2d_strt", 32'(a2d_strt), 32'(exp_strt));
                if (exp_strt) begin
                    if (e0 && e1) g = (m_last == 0) ? 1 : 0;
                    else          g = e0 ? 0 : 1;
                    m_svc      = g;
                    m_last_ch  = m_chan[g];
                    e.req      = g;
                    e.tmo      = cv_tmo;
                    e.res      = cv_tmo ? 12'h000 : cv_res;
                    e.done_cyc = cyc + (cv_tmo ? TMO : cv_k) + 1;
                    sb.push_back(e);
                end
                chk("busy", 32'(busy), 32'(m_svc >= 0));
                chk("a2d_chnnl", 32'(a2d_chnnl), 32'(m_last_ch));
                if (sb.size() != 0 && sb[0].done_cyc == cyc) begin
                    e = sb.pop_front();
                    chk("req0_cmplt", 32'(req0_cmplt), 32'(e.req == 0));
                    chk("req1_cmplt", 32'(req1_cmplt), 32'(e.req == 1));
                    chk("res_done", 32'(res), 32'(e.res));
                    chk("tmo_err", 32'(tmo_err), 32'(e.tmo));
                    m_pend[e.req] = 1'b0;
                    m_last        = e.req;
                    m_svc         = -1;
                    m_idle_free   = cyc + 1;
                    m_last_res    = e.res;
                end else begin
                    chk("no_cmplt", 32'({req1_cmplt, req0_cmplt, tmo_err}), 32'd0);
                    chk("res_hold", 32'(res), 32'(m_last_res));
                end
                // New starts after the completion so a start in DONE is accepted.
                if (req0_strt && !m_pend[0]) begin
                    m_pend[0] = 1'b1; m_chan[0] = req0_chnnl; m_issue[0] = cyc;
                end
                if (req1_strt && !m_pend[1]) begin
                    m_pend[1] = 1'b1; m_chan[1] = req1_chnnl; m_issue[1] = cyc;
                end
            end
        end
    end

    // Converter responder: mode 0 random (incl. timeouts, limit-cycle answers, stray completes), 1 fixed, 2 never answers.
    initial begin : converter
        int r;
        a2d_cmplt = 1'b0;
        a2d_res   = 12'h000;
        cv_cnt    = 0;
        cv_k      = 1;
        cv_tmo    = 1'b0;
        cv_res    = 12'h000;
        forever begin
            @(posedge clk);
            #1;
            a2d_cmplt = 1'b0;
            if (!rst_n) begin
                cv_cnt = 0;
            end else begin
                if (cv_cnt > 0) begin
                    cv_cnt--;
                    if (cv_cnt == 0) begin
                        a2d_cmplt = 1'b1;
                        a2d_res   = cv_res;
                    end
                end else if (cv_mode == 0 && !a2d_strt && $urandom_range(15) == 0) begin
                    a2d_cmplt = 1'b1;
                    a2d_res   = 12'($urandom);
                end
                if (a2d_strt) begin
                    cv_tmo = 1'b0;
                    cv_res = 12'($urandom);
                    if (cv_mode == 1) begin
                        cv_k   = cv_fix_k;
                        cv_res = cv_fix_res;
                    end else if (cv_mode == 2) begin
                        cv_tmo = 1'b1;
                    end else begin
                        r = int'($urandom_range(7));
                        if (r == 0)      cv_tmo = 1'b1;
                        else if (r == 1) cv_k = TMO;
                        else             cv_k = int'($urandom_range(6, 1));
                    end
                    // On abort, answer late (in DONE) with junk that must be ignored.
                    cv_cnt = cv_tmo ? TMO + 1 : cv_k;
                end
            end
        end
    end

    task automatic tick(input bit s0, input logic [2:0] c0, input bit s1, input logic [2:0] c1);
        @(posedge clk);
        #1;
        drain_chk  = 1'b0;
        req0_strt  = s0;
        req0_chnnl = s0 ? c0 : 3'($urandom);
        req1_strt  = s1;
        req1_chnnl = s1 ? c1 : 3'($urandom);
        if (restrobe_cnt > 0 && req0_cmplt) begin
            req0_strt = 1'b1; req0_chnnl = 3'($urandom); restrobe_cnt--;
        end
        if (restrobe_cnt > 0 && req1_cmplt) begin
            req1_strt = 1'b1; req1_chnnl = 3'($urandom); restrobe_cnt--;
        end
        if (rand_en) begin
            if ($urandom_range(7) == 0 || (req0_cmplt && $urandom_range(1) == 0)) begin
                req0_strt = 1'b1; req0_chnnl = 3'($urandom);
            end
            if ($urandom_range(7) == 0 || (req1_cmplt && $urandom_range(1) == 0)) begin
                req1_strt = 1'b1; req1_chnnl = 3'($urandom);
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        do begin
            tick(1'b0, 3'd0, 1'b0, 3'd0);
            n++;
        end while ((sb.size() != 0 || m_pend[0] || m_pend[1] || restrobe_cnt > 0) && n < budget);
        drain_ok  = (sb.size() == 0) && !m_pend[0] && !m_pend[1];
        drain_chk = 1'b1;
        tick(1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req0_strt = 1'b0;
        req1_strt = 1'b0;
        drain_chk = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    // Stimulus: directed scenarios followed by a random phase.
    initial begin : stimulus
        int n;
        rst_n        = 1'b1;
        req0_strt    = 1'b0;
        req0_chnnl   = 3'd0;
        req1_strt    = 1'b0;
        req1_chnnl   = 3'd0;
        drain_chk    = 1'b0;
        drain_ok     = 1'b0;
        restrobe_cnt = 0;
        rand_en      = 1'b0;
        cv_mode      = 1;
        cv_fix_k     = 8;
        cv_fix_res   = 12'hA5C;
        #2 rst_n = 1'b0;
        do_reset();

        // Single request: grant two cycles later, complete 8 cycles after the start.
        tick(1'b1, 3'd1, 1'b0, 3'd0);
        drain(100);

        // Simultaneous requests straight after reset: 0 then 1.
        do_reset();
        cv_fix_k = 3; cv_fix_res = 12'h5E1;
        tick(1'b1, 3'd4, 1'b1, 3'd7);
        drain(100);

        // Continuous contention: both re-strobe in their own DONE cycle, six conversions.
        do_reset();
        cv_mode = 0;
        restrobe_cnt = 4;
        tick(1'b1, 3'd2, 1'b1, 3'd6);
        drain(400);

        // Timeout on requester 1, then a normal conversion.
        cv_mode = 2;
        tick(1'b0, 3'd0, 1'b1, 3'd3);
        drain(100);
        cv_mode = 1; cv_fix_k = 5; cv_fix_res = 12'h3C3;
        tick(1'b0, 3'd0, 1'b1, 3'd2);
        drain(100);

        // Completion on the last watchdog cycle wins over the timeout.
        cv_fix_k = TMO; cv_fix_res = 12'hFFF;
        tick(1'b1, 3'd5, 1'b0, 3'd0);
        drain(100);

        // Duplicate start while pending is ignored.
        cv_fix_k = 4; cv_fix_res = 12'h0B7;
        tick(1'b1, 3'd2, 1'b0, 3'd0);
        tick(1'b0, 3'd0, 1'b0, 3'd0);
        tick(1'b1, 3'd5, 1'b0, 3'd0);
        drain(100);

        // Reset in the middle of a conversion with requester 1 pending.
        cv_fix_k = 12; cv_fix_res = 12'h777;
        tick(1'b1, 3'd6, 1'b0, 3'd0);
        n = 0;
        while (!a2d_strt && n < 20) begin
            tick(1'b0, 3'd0, 1'b0, 3'd0);
            n++;
        end
        repeat (2) tick(1'b0, 3'd0, 1'b0, 3'd0);
        tick(1'b0, 3'd0, 1'b1, 3'd5);
        tick(1'b0, 3'd0, 1'b0, 3'd0);
        do_reset();
        repeat (30) tick(1'b0, 3'd0, 1'b0, 3'd0);

        // Random traffic with random converter behaviour.
        cv_mode = 0;
        rand_en = 1'b1;
        repeat (3000) tick(1'b0, 3'd0, 1'b0, 3'd0);
        rand_en = 1'b0;
        drain(400);

        repeat (3) tick(1'b0, 3'd0, 1'b0, 3'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : time_limit
        #400000;
        $display("FAIL time_limit cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
